// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles every non-clock signal of the memory-access stage.
//
// Handshake rules:
//   ex side  : a bundle moves on a rising edge where ex_valid && ex_ready.
//              ex_ready is combinational; ex_valid must not depend on it.
//   dmem side: dmem_req rises with dmem_we/addr/wdata valid and all four hold
//              stable until the edge dmem_ack is sampled high (or the wait
//              times out). dmem_rdata is sampled on that same ack edge.
//              dmem_ack while dmem_req is low has no effect.
//   wb side  : wb_valid is a one-cycle pulse; other wb_* hold between pulses.
//
// Modports:
//   master - the stage itself (drives ex_ready, dmem_*, wb_*, status)
//   slave  - the surroundings (execute stage, data memory, write-back)
// state_dbg exposes the stage FSM (0 = IDLE, 1 = BUSY).
interface mem_stage_if #(
    parameter int DW = 32
);
    logic          ex_valid;
    logic          ex_ready;
    logic [31:0]   ex_ir;
    logic [DW-1:0] ex_alu_res;
    logic [DW-1:0] ex_b;
    logic          ex_sel;

    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    logic          wb_valid;
    logic [31:0]   wb_ir;
    logic [DW-1:0] wb_alu_res;
    logic [DW-1:0] wb_lmd;
    logic [4:0]    wb_rd;
    logic          wb_reg_we;
    logic          wb_br_taken;

    logic          halted;
    logic          err;
    logic          state_dbg;

    modport master (
        input  ex_valid, ex_ir, ex_alu_res, ex_b, ex_sel,
        output ex_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack,
        output wb_valid, wb_ir, wb_alu_res, wb_lmd, wb_rd, wb_reg_we, wb_br_taken,
        output halted, err, state_dbg
    );

    modport slave (
        output ex_valid, ex_ir, ex_alu_res, ex_b, ex_sel,
        input  ex_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack,
        input  wb_valid, wb_ir, wb_alu_res, wb_lmd, wb_rd, wb_reg_we, wb_br_taken,
        input  halted, err, state_dbg
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of a MIPS32-style pipeline.
// Takes the execute bundle, performs LW/SW over the dmem req/ack handshake
// (with a wait timeout), and emits a registered write-back bundle.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - mem_stage_if.master: ex_* in, dmem_* out/in, wb_* out,
//           halted/err sticky status, state_dbg FSM view
// Parameters:
//   DW      - data/address width
//   TIMEOUT - cycles dmem_req may stay high without dmem_ack (1..255)
module mem_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_stage_if.master     bus
);
    localparam logic [5:0] OP_LW    = 6'b110000;
    localparam logic [5:0] OP_SW    = 6'b110001;
    localparam logic [5:0] OP_HLT   = 6'b111111;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [7:0]    cnt;
    logic          ready;

    // Pending memory-op fields, held until the transaction resolves.
    logic [31:0]   p_ir;
    logic [DW-1:0] p_alu;
    logic [4:0]    p_rd;
    logic          p_we;
    logic          p_sel;
    logic          p_lw;

    // Decode of the offered instruction.
    logic [5:0]    op;
    logic [4:0]    d_rd;
    logic          d_we;
    logic          d_lw;
    logic          d_sw;
    logic          d_hlt;

    always_comb begin
        op    = bus.ex_ir[31:26];
        d_rd  = bus.ex_ir[20:16];
        d_we  = 1'b0;
        d_lw  = (op == OP_LW);
        d_sw  = (op == OP_SW);
        d_hlt = (op == OP_HLT);
        if (!op[5]) begin
            // ALU class: RR writes ir[15:11], RImm writes ir[20:16].
            d_we = 1'b1;
            if (!op[4]) d_rd = bus.ex_ir[15:11];
        end else if (d_lw) begin
            d_we = 1'b1;
        end
    end

    assign ready         = (state == IDLE) && !bus.halted && rst_n;
    assign bus.ex_ready  = ready;
    assign bus.state_dbg = (state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            p_ir            <= '0;
            p_alu           <= '0;
            p_rd            <= '0;
            p_we            <= 1'b0;
            p_sel           <= 1'b0;
            p_lw            <= 1'b0;
            bus.dmem_req    <= 1'b0;
            bus.dmem_we     <= 1'b0;
            bus.dmem_addr   <= '0;
            bus.dmem_wdata  <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_ir       <= '0;
            bus.wb_alu_res  <= '0;
            bus.wb_lmd      <= '0;
            bus.wb_rd       <= '0;
            bus.wb_reg_we   <= 1'b0;
            bus.wb_br_taken <= 1'b0;
            bus.halted      <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ex_valid && ready) begin
                        if (d_lw || d_sw) begin
                            state          <= BUSY;
                            cnt            <= '0;
                            p_ir           <= bus.ex_ir;
                            p_alu          <= bus.ex_alu_res;
                            p_rd           <= d_rd;
                            p_we           <= d_we;
                            p_sel          <= bus.ex_sel;
                            p_lw           <= d_lw;
                            bus.dmem_req   <= 1'b1;
                            bus.dmem_we    <= d_sw;
                            bus.dmem_addr  <= bus.ex_alu_res;
                            bus.dmem_wdata <= bus.ex_b;
                        end else begin
                            bus.wb_valid    <= 1'b1;
                            bus.wb_ir       <= bus.ex_ir;
                            bus.wb_alu_res  <= bus.ex_alu_res;
                            bus.wb_rd       <= d_rd;
                            bus.wb_reg_we   <= d_we;
                            bus.wb_br_taken <= bus.ex_sel;
                            if (d_hlt) bus.halted <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Ack is checked first so an ack on the last allowed
                    // cycle completes normally instead of timing out.
                    if (bus.dmem_ack || cnt == CNT_LAST) begin
                        state           <= IDLE;
                        bus.dmem_req    <= 1'b0;
                        bus.wb_valid    <= 1'b1;
                        bus.wb_ir       <= p_ir;
                        bus.wb_alu_res  <= p_alu;
                        bus.wb_rd       <= p_rd;
                        bus.wb_br_taken <= p_sel;
                        if (bus.dmem_ack) begin
                            bus.wb_reg_we <= p_we;
                            if (p_lw) bus.wb_lmd <= bus.dmem_rdata;
                        end else begin
                            bus.err       <= 1'b1;
                            bus.wb_reg_we <= 1'b0;
                            bus.wb_lmd    <= '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_stage_if #(.DW(DW)) bus ();

    mem_stage #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge; checks and drives happen here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] b, input logic sel);
        bus.ex_valid   = 1'b1;
        bus.ex_ir      = ir;
        bus.ex_alu_res = alu;
        bus.ex_b       = b;
        bus.ex_sel     = sel;
    endtask

    task automatic idle_ex();
        bus.ex_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"},      64'(bus.dmem_req),    64'd0);
        check_eq({tag, "_we"},       64'(bus.dmem_we),     64'd0);
        check_eq({tag, "_addr"},     64'(bus.dmem_addr),   64'd0);
        check_eq({tag, "_wdata"},    64'(bus.dmem_wdata),  64'd0);
        check_eq({tag, "_wbv"},      64'(bus.wb_valid),    64'd0);
        check_eq({tag, "_wbir"},     64'(bus.wb_ir),       64'd0);
        check_eq({tag, "_wbalu"},    64'(bus.wb_alu_res),  64'd0);
        check_eq({tag, "_wblmd"},    64'(bus.wb_lmd),      64'd0);
        check_eq({tag, "_wbrd"},     64'(bus.wb_rd),       64'd0);
        check_eq({tag, "_wbwe"},     64'(bus.wb_reg_we),   64'd0);
        check_eq({tag, "_wbbr"},     64'(bus.wb_br_taken), 64'd0);
        check_eq({tag, "_halted"},   64'(bus.halted),      64'd0);
        check_eq({tag, "_err"},      64'(bus.err),         64'd0);
        check_eq({tag, "_ready"},    64'(bus.ex_ready),    64'd0);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [31:0] IR_ADD  = 32'h0001_1000; // RR, rd=2
    localparam logic [31:0] IR_ADDI = 32'h4027_0005; // RImm, rd=7
    localparam logic [31:0] IR_LW5  = 32'hC005_0000; // LW rd=5
    localparam logic [31:0] IR_LW6  = 32'hC006_0000; // LW rd=6
    localparam logic [31:0] IR_SW   = 32'hC402_0000;
    localparam logic [31:0] IR_BNEZ = 32'hD460_0010;
    localparam logic [31:0] IR_HLT  = 32'hFC00_0000;

    int req_cycles;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ex_valid   = 1'b0;
        bus.ex_ir      = '0;
        bus.ex_alu_res = '0;
        bus.ex_b       = '0;
        bus.ex_sel     = 1'b0;
        bus.dmem_rdata = '0;
        bus.dmem_ack   = 1'b0;

        // Reset
        step();
        step();
        check_reset_values("rst");
        rst_n = 1'b1;
        #1;
        check_eq("rdy_after_rst", 64'(bus.ex_ready), 64'd1);

        // ALU ADD: one-cycle latency
        offer(IR_ADD, 32'h15, 32'h0, 1'b0);
        step();
        idle_ex();
        check_eq("add_wbv",  64'(bus.wb_valid),   64'd1);
        check_eq("add_rd",   64'(bus.wb_rd),      64'd2);
        check_eq("add_we",   64'(bus.wb_reg_we),  64'd1);
        check_eq("add_alu",  64'(bus.wb_alu_res), 64'h15);
        check_eq("add_ir",   64'(bus.wb_ir),      64'(IR_ADD));
        check_eq("add_req",  64'(bus.dmem_req),   64'd0);
        step();
        check_eq("add_pulse", 64'(bus.wb_valid),  64'd0);
        check_eq("add_hold",  64'(bus.wb_rd),     64'd2);

        // LW with ack in the third req cycle
        offer(IR_LW5, 32'h40, 32'h0, 1'b0);
        step();
        idle_ex();
        for (int i = 0; i < 3; i++) begin
            check_eq("lw_req",   64'(bus.dmem_req),  64'd1);
            check_eq("lw_addr",  64'(bus.dmem_addr), 64'h40);
            check_eq("lw_we",    64'(bus.dmem_we),   64'd0);
            check_eq("lw_rdy",   64'(bus.ex_ready),  64'd0);
            check_eq("lw_nowb",  64'(bus.wb_valid),  64'd0);
            if (i == 2) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        bus.dmem_ack = 1'b0;
        check_eq("lw_req_drop", 64'(bus.dmem_req),  64'd0);
        check_eq("lw_wbv",      64'(bus.wb_valid),  64'd1);
        check_eq("lw_lmd",      64'(bus.wb_lmd),    64'hDEAD_BEEF);
        check_eq("lw_rd",       64'(bus.wb_rd),     64'd5);
        check_eq("lw_we_wb",    64'(bus.wb_reg_we), 64'd1);
        check_eq("lw_rdy_back", 64'(bus.ex_ready),  64'd1);
        step();
        check_eq("lw_pulse",    64'(bus.wb_valid),  64'd0);

        // Stray ack with no request outstanding must do nothing
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h1111_1111;
        step();
        bus.dmem_ack = 1'b0;
        check_eq("stray_wbv", 64'(bus.wb_valid), 64'd0);
        check_eq("stray_lmd", 64'(bus.wb_lmd),   64'hDEAD_BEEF);

        // SW with immediate ack; ALU op offered at the ack edge
        offer(IR_SW, 32'h80, 32'h1234, 1'b0);
        step();
        check_eq("sw_req",   64'(bus.dmem_req),   64'd1);
        check_eq("sw_we",    64'(bus.dmem_we),    64'd1);
        check_eq("sw_wdata", 64'(bus.dmem_wdata), 64'h1234);
        check_eq("sw_addr",  64'(bus.dmem_addr),  64'h80);
        bus.dmem_ack = 1'b1;
        offer(IR_ADDI, 32'h99, 32'h0, 1'b0);
        step();
        bus.dmem_ack = 1'b0;
        check_eq("sw_req_drop", 64'(bus.dmem_req),  64'd0);
        check_eq("sw_wbv",      64'(bus.wb_valid),  64'd1);
        check_eq("sw_wbwe",     64'(bus.wb_reg_we), 64'd0);
        check_eq("sw_wbir",     64'(bus.wb_ir),     64'(IR_SW));
        check_eq("sw_rdy",      64'(bus.ex_ready),  64'd1);
        step();
        idle_ex();
        check_eq("addi_wbv", 64'(bus.wb_valid),  64'd1);
        check_eq("addi_ir",  64'(bus.wb_ir),     64'(IR_ADDI));
        check_eq("addi_rd",  64'(bus.wb_rd),     64'd7);
        check_eq("addi_we",  64'(bus.wb_reg_we), 64'd1);
        check_eq("addi_lmd", 64'(bus.wb_lmd),    64'hDEAD_BEEF);
        step();

        // LW with ack on the last allowed cycle: ack wins
        offer(IR_LW6, 32'h44, 32'h0, 1'b0);
        step();
        idle_ex();
        for (int i = 0; i < TIMEOUT; i++) begin
            check_eq("late_req", 64'(bus.dmem_req), 64'd1);
            if (i == TIMEOUT - 1) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = 32'hCAFE_F00D;
            end
            step();
        end
        bus.dmem_ack = 1'b0;
        check_eq("late_wbv", 64'(bus.wb_valid),  64'd1);
        check_eq("late_err", 64'(bus.err),       64'd0);
        check_eq("late_lmd", 64'(bus.wb_lmd),    64'hCAFE_F00D);
        check_eq("late_we",  64'(bus.wb_reg_we), 64'd1);
        step();

        // LW timeout: ack never comes
        offer(IR_LW6, 32'h100, 32'h0, 1'b0);
        step();
        idle_ex();
        req_cycles = 0;
        while (bus.dmem_req && req_cycles < 40) begin
            req_cycles++;
            step();
        end
        check_eq("to_req_cycles", 64'(req_cycles),    64'(TIMEOUT));
        check_eq("to_wbv",        64'(bus.wb_valid),  64'd1);
        check_eq("to_err",        64'(bus.err),       64'd1);
        check_eq("to_we",         64'(bus.wb_reg_we), 64'd0);
        check_eq("to_lmd",        64'(bus.wb_lmd),    64'd0);
        step();
        check_eq("to_pulse",      64'(bus.wb_valid),  64'd0);
        step();
        check_eq("to_err_sticky", 64'(bus.err),       64'd1);

        // BNEQZ taken, then HLT, then an ALU op that must never retire
        offer(IR_BNEZ, 32'h0, 32'h0, 1'b1);
        step();
        check_eq("br_wbv",   64'(bus.wb_valid),    64'd1);
        check_eq("br_taken", 64'(bus.wb_br_taken), 64'd1);
        check_eq("br_we",    64'(bus.wb_reg_we),   64'd0);
        offer(IR_HLT, 32'h0, 32'h0, 1'b0);
        step();
        check_eq("hlt_wbv",    64'(bus.wb_valid),    64'd1);
        check_eq("hlt_halted", 64'(bus.halted),      64'd1);
        check_eq("hlt_rdy",    64'(bus.ex_ready),    64'd0);
        check_eq("hlt_br",     64'(bus.wb_br_taken), 64'd0);
        offer(IR_ADD, 32'h77, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hlt_block_wbv", 64'(bus.wb_valid), 64'd0);
            check_eq("hlt_block_rdy", 64'(bus.ex_ready), 64'd0);
        end
        idle_ex();

        // Clear halt, then reset during an outstanding LW
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check_eq("unhalt_rdy", 64'(bus.ex_ready), 64'd1);
        offer(IR_LW5, 32'h60, 32'h0, 1'b0);
        step();
        idle_ex();
        check_eq("mid_req1", 64'(bus.dmem_req), 64'd1);
        step();
        check_eq("mid_req2", 64'(bus.dmem_req), 64'd1);
        rst_n = 1'b0;
        step();
        check_reset_values("mid");
        rst_n = 1'b1;
        step();
        check_eq("mid_nowb", 64'(bus.wb_valid), 64'd0);
        offer(IR_ADD, 32'h21, 32'h0, 1'b0);
        step();
        idle_ex();
        check_eq("post_wbv", 64'(bus.wb_valid),   64'd1);
        check_eq("post_alu", 64'(bus.wb_alu_res), 64'h21);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS32-style pipeline, sitting directly downstream of the execute stage and upstream of write-back. Consumes the execute stage's instruction, ALU result, store data and branch-taken flag, and performs loads/stores over a req/ack data-memory handshake. Stalls upstream while a memory transaction is outstanding and aborts it on timeout. Forwards a registered bundle (IR, ALU result, load data, destination register, write enable) to write-back, and latches a sticky halt.

## Interface
- DW, 32, data/address width
- TIMEOUT, 16, max cycles dmem_req may wait for dmem_ack (1..255)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  execute bundle valid this cycle
- ex_ready  out  1  stage can accept; combinational: state IDLE && !halted && rst_n
- ex_ir  in  32  instruction from execute
- ex_alu_res  in  DW  ALU result / effective address
- ex_b  in  DW  store data (register B)
- ex_sel  in  1  branch taken
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DW  byte address
- dmem_wdata  out  DW  store data
- dmem_rdata  in  DW  load data, valid with dmem_ack
- dmem_ack  in  1  transaction complete
- wb_valid  out  1  one-cycle pulse, write-back bundle valid
- wb_ir  out  32  instruction
- wb_alu_res  out  DW  ALU result
- wb_lmd  out  DW  load memory data
- wb_rd  out  5  destination register
- wb_reg_we  out  1  register file write enable
- wb_br_taken  out  1  registered ex_sel
- halted  out  1  sticky, HLT retired
- err  out  1  sticky, memory timeout occurred

## Operation
- Opcode = ex_ir[31:26]. Classes:
  - ALU: op[5]=0. RR when op[4]=0, rd=ir[15:11]; RImm when op[4]=1, rd=ir[20:16]; wb_reg_we=1.
  - LW 110000: rd=ir[20:16]; wb_reg_we=1.
  - SW 110001: wb_reg_we=0.
  - BEQZ 110100 / BNEQZ 110101: wb_reg_we=0. wb_br_taken=ex_sel.
  - HLT 111111: wb_reg_we=0; sets halted.
  - Any other: treated as NOP, wb_reg_we=0.
- Accept when ex_valid && ex_ready at the edge; capture ir, alu_res, b, sel.
- FSM states:
  - IDLE: non-memory ops go to write-back directly; LW/SW go to BUSY and assert dmem_req.
  - BUSY: hold dmem_req/we/addr/wdata stable; increment the wait counter each cycle.
    - On dmem_ack: LW latches dmem_rdata into wb_lmd. Go to IDLE.
    - On wait counter == TIMEOUT-1 with no ack: set err, drop req, issue wb_valid with wb_lmd=0 and wb_reg_we=0. Go to IDLE.
- dmem_ack while dmem_req=0 is ignored.
- HLT: halted set on the edge its wb_valid is issued. ex_ready is 0 from then on; the stage accepts nothing further until reset.
- wb_lmd holds its last value for non-load ops. All wb_* except wb_valid hold between pulses.

## Timing
- Reset (rst_n=0 at edge): state IDLE, counter 0.
  - Outputs: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_ir=0, wb_alu_res=0, wb_lmd=0, wb_rd=0, wb_reg_we=0, wb_br_taken=0, halted=0, err=0.
  - ex_ready=0 while rst_n=0.
- Reset mid-transaction: dmem_req=0 after that edge, and no wb_valid is issued for the aborted op.
- Non-memory op accepted at edge N: wb_valid=1 during cycle N..N+1, so 1-cycle latency. Back-to-back accepts give one pulse per cycle.
- Memory op accepted at edge N:
  - dmem_req=1 from edge N, with ex_ready=0.
  - dmem_ack sampled high at edge M: dmem_req=0 and wb_valid=1 after edge M. ex_ready=1 in the same cycle, so a new op may be accepted at edge M+1.
  - Minimum latency, ack in the first req cycle: wb_valid after edge N+1.
- Timeout: req held exactly TIMEOUT cycles. If dmem_ack arrives on the last cycle, ack wins: normal completion, err unchanged.
- wb_valid is never high two cycles for one instruction.

## Test plan
- ALU ADD, ir=0x00011000 (op 000000, rd=ir[15:11]=2), alu_res=0x15 accepted at edge N -> wb_valid after N, wb_rd=2, wb_reg_we=1, wb_alu_res=0x15.
- LW (op 110000, ir[20:16]=5) with alu_res=0x40, memory acks 3 cycles after req with rdata=0xDEADBEEF:
  - dmem_req=1 for 3 cycles, addr=0x40, dmem_we=0, ex_ready=0 throughout.
  - Then wb_valid, wb_lmd=0xDEADBEEF, wb_rd=5, wb_reg_we=1.
- SW with alu_res=0x80, b=0x1234, immediate ack -> dmem_we=1, wdata=0x1234 for one cycle; wb_valid next; wb_reg_we=0; an ALU op offered at the ack edge is accepted the following edge.
- LW, ack never arrives, TIMEOUT=16 -> req high exactly 16 cycles; err=1; wb_valid with wb_reg_we=0, wb_lmd=0; err stays 1 until reset.
- BNEQZ with ex_sel=1, then HLT, then ALU op held valid -> wb_br_taken=1, wb_reg_we=0; halted=1 after HLT; ex_ready=0; the ALU op never produces wb_valid.
- rst_n=0 on the 2nd cycle of an outstanding LW -> dmem_req=0, no wb_valid, all outputs at reset values; after release the stage accepts a new op.
